// File: rtl/conv2_mac_sched.sv
// Tap-serial conv2 MAC sequencer: 3 channels x 25 taps through one shared MAC, one 14-bit result per window.
// Optional ZERO_SKIP_EN: hold the MAC pipeline on zero operands and count the skipped MACs.
module conv2_mac_sched #(
  parameter int NUM_CH  = 3,
  parameter int TAPS    = 25,
  parameter int ACC_W   = 20,
  parameter int OUT_LSB = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               win_valid,
  output logic               win_ready,
  input  logic               flush,
  output logic               rd_en,
  output logic [1:0]         rd_ch,
  output logic [4:0]         rd_tap,
  output logic [6:0]         wt_addr,
  input  logic signed [11:0] rd_data,
  input  logic signed [7:0]  wt_data,
  output logic [13:0]        conv_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [6:0]         skip_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  localparam logic [4:0] LAST_TAP = 5'(TAPS - 1);
  localparam logic [1:0] LAST_CH  = 2'(NUM_CH - 1);

  state_t                  state_q;
  logic                    rd_en_q, drain_q, out_valid_q;
  logic [1:0]              ch_q;
  logic [4:0]              tap_q;
  logic [6:0]              addr_q, skip_q;
  logic [13:0]             conv_q;
  // [0] data on bus, [1] operand regs loaded, [2] product reg loaded
  logic [2:0]              vld_pipe_q;
  logic signed [11:0]      op_a_q;
  logic signed [7:0]       op_b_q;
  logic signed [19:0]      prod_q;
  logic signed [ACC_W-1:0] acc_q;

  logic signed [19:0]      mul_d;
  logic signed [ACC_W-1:0] prod_ext_d, mul_ext_d, acc_fin_d;
  logic                    op_zero_d;

`ifdef ZERO_SKIP_EN
  assign op_zero_d = (rd_data == 12'sd0) || (wt_data == 8'sd0);
`else
  assign op_zero_d = 1'b0;
`endif

  assign mul_d      = 20'(op_a_q) * 20'(op_b_q);
  assign prod_ext_d = ACC_W'(prod_q);
  assign mul_ext_d  = ACC_W'(mul_d);
  // The last two MACs are still in flight when DRAIN ends; fold them into the result.
  assign acc_fin_d  = acc_q + (vld_pipe_q[2] ? prod_ext_d : '0)
                            + (vld_pipe_q[1] ? mul_ext_d  : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_en_q     <= 1'b0;
      drain_q     <= 1'b0;
      out_valid_q <= 1'b0;
      ch_q        <= '0;
      tap_q       <= '0;
      addr_q      <= '0;
      skip_q      <= '0;
      conv_q      <= '0;
      vld_pipe_q  <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
    end else if (flush) begin
      state_q     <= IDLE;
      rd_en_q     <= 1'b0;
      drain_q     <= 1'b0;
      out_valid_q <= 1'b0;
      ch_q        <= '0;
      tap_q       <= '0;
      addr_q      <= '0;
      vld_pipe_q  <= '0;
      acc_q       <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1], vld_pipe_q[0] & ~op_zero_d, rd_en_q};
      if (vld_pipe_q[0] && !op_zero_d) begin
        op_a_q <= rd_data;
        op_b_q <= wt_data;
      end
      if (vld_pipe_q[1]) prod_q <= mul_d;
      if (vld_pipe_q[2]) acc_q  <= acc_q + prod_ext_d;
      if (vld_pipe_q[0] && op_zero_d) skip_q <= skip_q + 7'd1;

      case (state_q)
        IDLE: if (win_valid) begin
          state_q <= RUN;
          rd_en_q <= 1'b1;
          ch_q    <= '0;
          tap_q   <= '0;
          addr_q  <= '0;
          acc_q   <= '0;
          skip_q  <= '0;
        end
        RUN: begin
          if (tap_q == LAST_TAP) begin
            tap_q <= '0;
            if (ch_q == LAST_CH) begin
              state_q <= DRAIN;
              rd_en_q <= 1'b0;
              drain_q <= 1'b0;
              ch_q    <= '0;
              addr_q  <= '0;
            end else begin
              ch_q   <= ch_q + 2'd1;
              addr_q <= addr_q + 7'd1;
            end
          end else begin
            tap_q  <= tap_q + 5'd1;
            addr_q <= addr_q + 7'd1;
          end
        end
        DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
            conv_q      <= acc_fin_d[OUT_LSB+13:OUT_LSB];
          end
        end
        OUT: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign win_ready = (state_q == IDLE);
  assign rd_en     = rd_en_q;
  assign rd_ch     = ch_q;
  assign rd_tap    = tap_q;
  assign wt_addr   = addr_q;
  assign conv_out  = conv_q;
  assign out_valid = out_valid_q;
  assign skip_cnt  = skip_q;

endmodule
